apb_timer_mc: RTL and testbench
===============================

// Module: apb_timer_mc
//
// PURPOSE
//  Multi-channel APB3 timer peripheral with the register file built in. Supersedes the single-channel
//  APB wrapper around the rv_timer core. NUM_CH independent up-counters, each with its own prescaler,
//  compare value, auto-reload/one-shot mode and sticky expiry flag, plus a maskable per-channel irq.
//  Sits on the peripheral APB bus next to the other common peripheral IPs; irqs go to the PLIC/core.
//
// PARAMETERS
//  APB_ADDR_WIDTH  9   APB address width; byte addresses, word aligned (PADDR[1:0] ignored)
//  NUM_CH          4   number of timer channels, 1..16
//  CNT_WIDTH       32  counter/compare width, 1..32; register reads zero-extended to 32 b
//  PRE_WIDTH       12  prescaler width, 1..16
//
// PORTS
//  HCLK      in   1               the single clock; all state on rising edge
//  HRESET    in   1               asynchronous, active-high reset
//  PADDR     in   APB_ADDR_WIDTH  APB address
//  PWDATA    in   32              APB write data
//  PWRITE    in   1               1 = write, 0 = read
//  PSEL      in   1               APB select
//  PENABLE   in   1               APB access phase
//  PRDATA    out  32              read data, valid when PSEL&PENABLE&!PWRITE, else 0
//  PREADY    out  1               tied 1 (zero wait states)
//  PSLVERR   out  1               error response (see CONFIGURATION)
//  irq_o     out  NUM_CH          per-channel irq = STATUS.expired & IRQ_EN[ch]
//  irq_any_o out  1               OR of irq_o
//
// BEHAVIOUR
//  Register map: channel ch at base ch*0x10.
//   +0x0 CTRL   [0] EN, [1] AUTO_RELOAD, [8+:PRE_WIDTH] PRESCALE                       (RW)
//   +0x4 COUNT  [CNT_WIDTH-1:0]                                                        (RW)
//   +0x8 CMP    [CNT_WIDTH-1:0]                                                        (RW)
//   +0xC STATUS [0] expired, write-1-to-clear                                          (RW1C)
//   0x100 IRQ_EN [NUM_CH-1:0] (RW);  0x104 IRQ_PEND [NUM_CH-1:0] = irq_o (RO, writes ignored)
//  Access: write commits on the edge where PSEL&PENABLE&PWRITE; read is combinational in the access
//   phase; setup phase has no side effects. Unused register bits read 0, writes to them ignored.
//  Reset: all registers, prescaler counters, PRDATA, PSLVERR, irq_o, irq_any_o = 0.
//  Per channel, while EN=1: prescaler pcnt counts 0..PRESCALE; tick when pcnt==PRESCALE, then pcnt<=0.
//   On tick: if COUNT==CMP -> expired<=1; COUNT<=0 if AUTO_RELOAD, else COUNT holds and EN<=0.
//            else COUNT<=COUNT+1, modulo 2^CNT_WIDTH (wrap-around; CMP<COUNT matches after wrap).
//   First expiry from COUNT=0: (PRESCALE+1)*(CMP+1) cycles after the EN write edge; auto-reload period same.
//   PRESCALE=0 -> tick every cycle. EN=0 -> pcnt<=0, COUNT frozen.
//  Simultaneous events (same edge):
//   - APB write to COUNT and tick: write wins, no increment, no match evaluation that cycle.
//   - STATUS W1C and hardware set: set wins (expired stays 1).
//   - CTRL write clearing EN and tick: EN=0 wins, tick ignored.
//   - One-shot expiry clearing EN and CTRL write: CTRL write wins.
//  irq_o/irq_any_o are combinational from registered state; level until STATUS cleared or IRQ_EN=0.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous); no irq glitch held.
//
// CONFIGURATION
//  APB_TIMER_PSLVERR_EN defined: PSLVERR=1 in access phase for an unmapped address (channel index
//   >= NUM_CH, offsets other than 0x100/0x104 at 0x100 and above) or a write to IRQ_PEND; an errored
//   write has no effect and an errored read returns 0.
//  Not defined: PSLVERR tied 0; unmapped reads return 0, unmapped writes ignored.
//
// TESTING
//  1 Reset: assert HRESET mid-count -> every register reads 0, irq_o=0, PREADY=1, no tick for 5 cycles.
//  2 ch0 CMP=3, PRESCALE=1, AUTO_RELOAD=1, IRQ_EN=1, EN=1 -> irq_o[0] rises 8 cycles after EN write;
//    COUNT reads 0 afterwards; W1C clears it; re-rises every 8 cycles.
//  3 ch2 one-shot CMP=5, PRESCALE=0 -> expired after 6 cycles, CTRL.EN reads 0, COUNT holds 5.
//  4 COUNT=0xFFFF_FFFE, CMP=1, PRESCALE=0 -> wraps to 0, expired 4 cycles after EN (FFFFFFFE,FFFFFFFF,0,1).
//  5 Same-edge collisions: W1C on expiry edge -> expired stays 1; COUNT write on tick -> COUNT=written.
//  6 PSLVERR_EN build: read 0x040 with NUM_CH=4 -> PSLVERR=1, PRDATA=0; write 0x104 -> PSLVERR=1, IRQ_PEND unchanged;
//    without macro -> PSLVERR=0 for both.

Source files
------------

// File: rtl/apb_timer_mc.sv
// apb_timer_mc - multi-channel APB3 timer peripheral with built-in register file.
//
// Each of NUM_CH channels owns a prescaler, an up-counter, a compare value,
// an auto-reload/one-shot mode bit and a sticky expiry flag. A per-channel
// irq is raised while the flag is set and the channel's IRQ_EN bit is set.
//
// Register map (byte addresses, PADDR[1:0] ignored), channel ch at ch*0x10:
//   +0x0 CTRL   [0] EN, [1] AUTO_RELOAD, [8+:PRE_WIDTH] PRESCALE   RW
//   +0x4 COUNT  [CNT_WIDTH-1:0]                                    RW
//   +0x8 CMP    [CNT_WIDTH-1:0]                                    RW
//   +0xC STATUS [0] expired                                        RW1C
//   0x100 IRQ_EN   [NUM_CH-1:0]                                    RW
//   0x104 IRQ_PEND [NUM_CH-1:0] (= irq_o)                          RO
//
// Build option: define APB_TIMER_PSLVERR_EN to answer unmapped accesses and
// writes to IRQ_PEND with PSLVERR; otherwise PSLVERR is tied low.
//
// Ports:
//   HCLK, HRESET        clock, asynchronous active-high reset
//   PADDR/PWDATA/PWRITE APB request
//   PSEL/PENABLE        APB setup/access phase qualifiers
//   PRDATA              read data (0 outside a read access phase)
//   PREADY              always 1 (zero wait states)
//   PSLVERR             error response
//   irq_o               per-channel interrupt level
//   irq_any_o           OR of irq_o
module apb_timer_mc #(
  parameter int unsigned APB_ADDR_WIDTH = 9,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned PRE_WIDTH      = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [NUM_CH-1:0]         irq_o,
  output logic                      irq_any_o
);

  // Address decode
  logic        access;
  logic        wr;
  logic [31:0] addr;
  logic        upper;
  logic [3:0]  chn;
  logic [1:0]  off;
  logic        sel_irq_en;
  logic        sel_irq_pend;

  assign access       = PSEL && PENABLE;
  assign wr           = access && PWRITE;
  assign addr         = 32'(PADDR);
  assign upper        = |addr[31:8];
  assign chn          = addr[7:4];
  assign off          = addr[3:2];
  assign sel_irq_en   = (addr[31:2] == 30'h40);
  assign sel_irq_pend = (addr[31:2] == 30'h41);

  // Channel state
  logic [NUM_CH-1:0]    en;
  logic [NUM_CH-1:0]    auto_reload;
  logic [NUM_CH-1:0]    expired;
  logic [NUM_CH-1:0]    irq_en;
  logic [PRE_WIDTH-1:0] prescale [NUM_CH];
  logic [PRE_WIDTH-1:0] pcnt     [NUM_CH];
  logic [CNT_WIDTH-1:0] count    [NUM_CH];
  logic [CNT_WIDTH-1:0] cmp      [NUM_CH];

  // Per-channel strobes
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_count;
  logic [NUM_CH-1:0] wr_cmp;
  logic [NUM_CH-1:0] wr_status;
  logic [NUM_CH-1:0] kill;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] step_cnt;

  // Collision priorities are folded into the strobes: a CTRL write that
  // clears EN suppresses the tick, and a COUNT write suppresses both the
  // increment and the compare on that edge.
  always_comb begin
    wr_ctrl   = '0;
    wr_count  = '0;
    wr_cmp    = '0;
    wr_status = '0;
    kill      = '0;
    tick      = '0;
    fire      = '0;
    step_cnt  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr && !upper && (chn == 4'(i))) begin
        wr_ctrl[i]   = (off == 2'd0);
        wr_count[i]  = (off == 2'd1);
        wr_cmp[i]    = (off == 2'd2);
        wr_status[i] = (off == 2'd3);
      end
      kill[i]     = wr_ctrl[i] && !PWDATA[0];
      tick[i]     = en[i] && (pcnt[i] == prescale[i]) && !kill[i];
      fire[i]     = tick[i] && !wr_count[i] && (count[i] == cmp[i]);
      step_cnt[i] = tick[i] && !wr_count[i] && (count[i] != cmp[i]);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      en          <= '0;
      auto_reload <= '0;
      expired     <= '0;
      irq_en      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        prescale[i] <= '0;
        pcnt[i]     <= '0;
        count[i]    <= '0;
        cmp[i]      <= '0;
      end
    end else begin
      if (wr && sel_irq_en) begin
        irq_en <= PWDATA[NUM_CH-1:0];
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!en[i] || kill[i] || (pcnt[i] == prescale[i])) begin
          pcnt[i] <= '0;
        end else begin
          pcnt[i] <= pcnt[i] + PRE_WIDTH'(1);
        end

        // A CTRL write overrides the one-shot self-disable on the same edge.
        if (wr_ctrl[i]) begin
          en[i]          <= PWDATA[0];
          auto_reload[i] <= PWDATA[1];
          prescale[i]    <= PWDATA[8 +: PRE_WIDTH];
        end else if (fire[i] && !auto_reload[i]) begin
          en[i] <= 1'b0;
        end

        if (wr_count[i]) begin
          count[i] <= PWDATA[CNT_WIDTH-1:0];
        end else if (step_cnt[i]) begin
          count[i] <= count[i] + CNT_WIDTH'(1);
        end else if (fire[i] && auto_reload[i]) begin
          count[i] <= '0;
        end

        if (wr_cmp[i]) begin
          cmp[i] <= PWDATA[CNT_WIDTH-1:0];
        end

        // Hardware set beats a same-edge write-1-to-clear.
        if (fire[i]) begin
          expired[i] <= 1'b1;
        end else if (wr_status[i] && PWDATA[0]) begin
          expired[i] <= 1'b0;
        end
      end
    end
  end

  assign irq_o     = expired & irq_en;
  assign irq_any_o = |irq_o;
  assign PREADY    = 1'b1;

  // Read mux; unmapped or non-read cycles return 0.
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (access && !PWRITE) begin
      if (sel_irq_en) begin
        rdata[NUM_CH-1:0] = irq_en;
      end else if (sel_irq_pend) begin
        rdata[NUM_CH-1:0] = irq_o;
      end else if (!upper) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (chn == 4'(i)) begin
            case (off)
              2'd0: begin
                rdata[0]              = en[i];
                rdata[1]              = auto_reload[i];
                rdata[8 +: PRE_WIDTH] = prescale[i];
              end
              2'd1:    rdata[CNT_WIDTH-1:0] = count[i];
              2'd2:    rdata[CNT_WIDTH-1:0] = cmp[i];
              default: rdata[0]             = expired[i];
            endcase
          end
        end
      end
    end
  end

  assign PRDATA = rdata;

`ifdef APB_TIMER_PSLVERR_EN
  logic ch_mapped;
  logic mapped;

  assign ch_mapped = (32'(chn) < NUM_CH);
  assign mapped    = upper ? (sel_irq_en || sel_irq_pend) : ch_mapped;
  assign PSLVERR   = access && (!mapped || (PWRITE && sel_irq_pend));
`else
  assign PSLVERR = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], PWDATA};

endmodule

// File: tb/tb_apb_timer_mc.sv
// Self-checking bench for apb_timer_mc: register access table, hand-written
// timing/collision sequences, randomized runs against an arithmetic model,
// and an asynchronous reset in mid-operation.
module tb_apb_timer_mc;

  typedef longint unsigned u64;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [8:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [3:0]  irq;
  logic        irq_any;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  u64          cyc = 0;
  u64          en_cyc = 0;

`ifdef APB_TIMER_PSLVERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  apb_timer_mc #(
    .APB_ADDR_WIDTH(9),
    .NUM_CH(4),
    .CNT_WIDTH(32),
    .PRE_WIDTH(12)
  ) dut (
    .HCLK(hclk),
    .HRESET(hreset),
    .PADDR(paddr),
    .PWDATA(pwdata),
    .PWRITE(pwrite),
    .PSEL(psel),
    .PENABLE(penable),
    .PRDATA(prdata),
    .PREADY(pready),
    .PSLVERR(pslverr),
    .irq_o(irq),
    .irq_any_o(irq_any)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic apb_write(input logic [8:0] a, input logic [31:0] d, output logic err);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge hclk);
    #1 penable = 1'b1;
    #2 err = pslverr;
    @(posedge hclk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [8:0] a, output logic [31:0] d, output logic err);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge hclk);
    #1 penable = 1'b1;
    #2 d = prdata; err = pslverr;
    @(posedge hclk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
  endtask

  task automatic rd_chk(input string nm, input logic [8:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_read(a, d, e);
    chk(nm, d, exp);
  endtask

  // Step until target cycles after en_cyc, expecting irq bit b to rise exactly there.
  task automatic wait_rise(input string nm, input int unsigned b, input u64 target);
    while ((cyc - en_cyc) < target) begin
      step();
      chk(nm, 32'(irq[b]), 32'((cyc - en_cyc) == target));
    end
  endtask

  // Timer behaviour from its rules: n ticks after t cycles; first expiry
  // after K ticks; thereafter reload period CMP+1 or hold at CMP.
  task automatic predict(input u64 t, input logic [31:0] cmpv, input logic [31:0] cnt0,
                         input int unsigned p, input bit ar,
                         output logic [31:0] e_cnt, output bit e_en, output bit e_exp);
    u64 n, k, m;
    m = 64'hFFFF_FFFF;
    n = t / (u64'(p) + 1);
    k = ((u64'(cmpv) - u64'(cnt0)) & m) + 1;
    if (n < k) begin
      e_exp = 1'b0;
      e_en  = 1'b1;
      e_cnt = 32'((u64'(cnt0) + n) & m);
    end else begin
      e_exp = 1'b1;
      if (ar) begin
        e_en  = 1'b1;
        e_cnt = 32'((n - k) % (u64'(cmpv) + 1));
      end else begin
        e_en  = 1'b0;
        e_cnt = cmpv;
      end
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    bit          err;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [31:0] d, e_cnt, cmpv, cnt0;
    logic        e;
    bit          e_en, e_exp, ar;
    int unsigned ch, p, w;
    logic [8:0]  base;
    u64          ts;

    tbl[0]  = '{1'b1, 9'h018, 32'h1234_5678, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 9'h018, 32'h0, 32'h1234_5678, 1'b0};
    tbl[2]  = '{1'b0, 9'h01B, 32'h0, 32'h1234_5678, 1'b0};
    tbl[3]  = '{1'b1, 9'h030, 32'hFFFF_FFFE, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 9'h030, 32'h0, 32'h000F_FF02, 1'b0};
    tbl[5]  = '{1'b1, 9'h034, 32'hDEAD_BEEF, 32'h0, 1'b0};
    tbl[6]  = '{1'b0, 9'h034, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[7]  = '{1'b0, 9'h040, 32'h0, 32'h0, ERR};
    tbl[8]  = '{1'b1, 9'h100, 32'hFFFF_FFF0, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 9'h100, 32'h0, 32'h0, 1'b0};
    tbl[10] = '{1'b1, 9'h100, 32'hFFFF_FFFA, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 9'h100, 32'h0, 32'h0000_000A, 1'b0};
    tbl[12] = '{1'b1, 9'h104, 32'h0000_000F, 32'h0, ERR};
    tbl[13] = '{1'b0, 9'h104, 32'h0, 32'h0, 1'b0};
    tbl[14] = '{1'b0, 9'h108, 32'h0, 32'h0, ERR};
    tbl[15] = '{1'b0, 9'h03C, 32'h0, 32'h0, 1'b0};
    tbl[16] = '{1'b1, 9'h050, 32'h0000_0001, 32'h0, ERR};
    tbl[17] = '{1'b0, 9'h1FC, 32'h0, 32'h0, ERR};

    // Reset state
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_irq_any", 32'(irq_any), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    @(negedge hclk) hreset = 1'b0;
    step();

    // Register access table
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].is_wr) begin
        apb_write(tbl[i].addr, tbl[i].data, e);
        chk($sformatf("tbl%0d_wr_err", i), 32'(e), 32'(tbl[i].err));
      end else begin
        apb_read(tbl[i].addr, d, e);
        chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
        chk($sformatf("tbl%0d_rd_err", i), 32'(e), 32'(tbl[i].err));
      end
    end

    // Auto-reload on ch0: CMP=3, PRESCALE=1 -> period 8
    wr(9'h100, 32'h1);
    wr(9'h008, 32'd3);
    wr(9'h000, 32'h103);
    en_cyc = cyc;
    wait_rise("ar_first_irq", 0, 8);
    rd_chk("ar_count_after", 9'h004, 32'h0);
    wr(9'h00C, 32'h1);
    chk("ar_w1c", 32'(irq[0]), 32'h0);
    wait_rise("ar_second_irq", 0, 16);
    wr(9'h00C, 32'h1);
    wait_rise("ar_third_irq", 0, 24);
    wr(9'h000, 32'h0);
    wr(9'h00C, 32'h1);

    // One-shot on ch2: CMP=5, PRESCALE=0
    wr(9'h100, 32'hF);
    wr(9'h028, 32'd5);
    wr(9'h020, 32'h1);
    en_cyc = cyc;
    wait_rise("os_irq", 2, 6);
    rd_chk("os_ctrl_en_cleared", 9'h020, 32'h0);
    rd_chk("os_count_hold", 9'h024, 32'd5);
    rd_chk("os_status", 9'h02C, 32'h1);
    chk("os_irq_any", 32'(irq_any), 32'h1);

    // Wrap-around on ch1
    wr(9'h014, 32'hFFFF_FFFE);
    wr(9'h018, 32'd1);
    wr(9'h010, 32'h1);
    en_cyc = cyc;
    wait_rise("wrap_irq", 1, 4);
    rd_chk("wrap_count", 9'h014, 32'd1);

    // W1C on the expiry edge: expired must stay set
    wr(9'h004, 32'h0);
    wr(9'h008, 32'd3);
    wr(9'h00C, 32'h1);
    wr(9'h000, 32'h3);
    en_cyc = cyc;
    while ((cyc - en_cyc) < 6) step();
    wr(9'h00C, 32'h1);
    rd_chk("col_w1c_vs_set", 9'h00C, 32'h1);
    step();
    wr(9'h00C, 32'h1);
    rd_chk("col_w1c_plain", 9'h00C, 32'h0);
    wr(9'h000, 32'h0);
    wr(9'h00C, 32'h1);

    // COUNT write on the matching tick: written value wins, no expiry
    wr(9'h01C, 32'h1);
    wr(9'h014, 32'h0);
    wr(9'h018, 32'd5);
    wr(9'h010, 32'h1);
    en_cyc = cyc;
    while ((cyc - en_cyc) < 4) step();
    wr(9'h014, 32'h40);
    chk("col_cntwr_irq", 32'(irq[1]), 32'h0);
    rd_chk("col_cntwr_count", 9'h014, 32'h41);
    rd_chk("col_cntwr_en", 9'h010, 32'h1);
    wr(9'h010, 32'h0);

    // CTRL write clearing EN on the matching tick: tick ignored
    wr(9'h02C, 32'h1);
    wr(9'h024, 32'h0);
    wr(9'h028, 32'd2);
    wr(9'h020, 32'h1);
    en_cyc = cyc;
    step();
    wr(9'h020, 32'h0);
    chk("col_dis_irq", 32'(irq[2]), 32'h0);
    rd_chk("col_dis_count", 9'h024, 32'd2);
    rd_chk("col_dis_status", 9'h02C, 32'h0);

    // CTRL write on a one-shot expiry edge: written EN survives
    wr(9'h024, 32'h0);
    wr(9'h020, 32'h1);
    en_cyc = cyc;
    step();
    wr(9'h020, 32'h3);
    rd_chk("col_os_ctrl", 9'h020, 32'h3);
    rd_chk("col_os_status", 9'h02C, 32'h1);
    wr(9'h020, 32'h0);

    // Randomized runs against the model
    wr(9'h100, 32'hF);
    for (int it = 0; it < 30; it++) begin
      ch   = $urandom_range(0, 3);
      base = 9'(ch * 16);
      wr(base, 32'h0);
      wr(base + 9'hC, 32'h1);
      if ($urandom_range(0, 1) == 1) cmpv = $urandom_range(0, 6);
      else cmpv = $urandom;
      cnt0 = cmpv - $urandom_range(0, 6);
      p    = $urandom_range(0, 3);
      ar   = 1'($urandom_range(0, 1));
      wr(base + 9'h8, cmpv);
      wr(base + 9'h4, cnt0);
      wr(base, 32'h1 | (32'(ar) << 1) | (32'(p) << 8));
      en_cyc = cyc;
      w = $urandom_range(0, 35);
      for (int k = 0; k < int'(w); k++) begin
        step();
        predict(cyc - en_cyc, cmpv, cnt0, p, ar, e_cnt, e_en, e_exp);
        chk($sformatf("rnd%0d_irq", it), 32'(irq[ch]), 32'(e_exp));
      end
      ts = cyc - en_cyc + 1;
      predict(ts, cmpv, cnt0, p, ar, e_cnt, e_en, e_exp);
      rd_chk($sformatf("rnd%0d_count", it), base + 9'h4, e_cnt);
      ts = cyc - en_cyc + 1;
      predict(ts, cmpv, cnt0, p, ar, e_cnt, e_en, e_exp);
      rd_chk($sformatf("rnd%0d_ctrl", it), base,
             32'(e_en) | (32'(ar) << 1) | (32'(p) << 8));
      ts = cyc - en_cyc + 1;
      predict(ts, cmpv, cnt0, p, ar, e_cnt, e_en, e_exp);
      rd_chk($sformatf("rnd%0d_status", it), base + 9'hC, 32'(e_exp));
    end

    // Asynchronous reset in mid-operation
    wr(9'h000, 32'h0);
    wr(9'h004, 32'h0);
    wr(9'h008, 32'd1);
    wr(9'h00C, 32'h1);
    wr(9'h000, 32'h3);
    repeat (4) step();
    chk("mid_pre_irq_any", 32'(irq_any), 32'h1);
    @(negedge hclk);
    #2 hreset = 1'b1;
    #1;
    chk("mid_async_irq", 32'(irq), 32'h0);
    chk("mid_async_irq_any", 32'(irq_any), 32'h0);
    @(posedge hclk);
    @(posedge hclk);
    @(negedge hclk) hreset = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mid_idle_irq", 32'(irq), 32'h0);
    end
    chk("mid_pready", 32'(pready), 32'h1);
    for (int a = 0; a < 64; a += 4) begin
      rd_chk($sformatf("mid_reg_%03h", a), 9'(a), 32'h0);
    end
    rd_chk("mid_irq_en", 9'h100, 32'h0);
    rd_chk("mid_irq_pend", 9'h104, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
